// File: rtl/muladd2_dot_acc.sv
`default_nettype none
// ============================================================================
// muladd2_dot_acc : pipelined 2-bit code-pair dot product with saturating acc
// Revision 1.0
// ============================================================================
module muladd2_dot_acc #(
    parameter int LANES = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*LANES-1:0]      in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_sat
);

    localparam int SUM_W = $clog2(9*LANES+1) + 1;
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic signed [3:0] decode(input logic [1:0] code);
        case (code)
            2'b00:   decode = -4'sd3;
            2'b01:   decode = -4'sd1;
            2'b10:   decode = 4'sd1;
            default: decode = 4'sd3;
        endcase
    endfunction

    logic                    adv;
    logic signed [SUM_W-1:0] lane_sum;
    logic signed [7:0]       prod;

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [SUM_W-1:0] s1_sum;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    sat;

    logic signed [EXT_W-1:0] sum_ext;
    logic                    ovf;
    logic signed [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0]        cnt_next;
    logic                    sat_next;

    // Output register doubles as the skid: everything holds while it is full and unconsumed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    always_comb begin
        lane_sum = '0;
        prod     = '0;
        for (int i = 0; i < LANES; i++) begin
            prod     = decode(in_data[4*i +: 2]) * decode(in_data[4*i+2 +: 2]);
            lane_sum = lane_sum + SUM_W'(prod);
        end
    end

    // One guard bit is enough: |lane_sum| is far below the accumulator range.
    assign sum_ext  = {acc[ACC_W-1], acc} + EXT_W'(s1_sum);
    assign ovf      = sum_ext[ACC_W] != sum_ext[ACC_W-1];
    assign acc_next = ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX) : sum_ext[ACC_W-1:0];
    assign cnt_next = (&cnt) ? cnt : cnt + 1'b1;
    assign sat_next = sat | ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sum    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_last   <= in_valid && in_last;
            s1_sum    <= lane_sum;
            out_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    out_valid <= 1'b1;
                    out_acc   <= acc_next;
                    out_beats <= cnt_next;
                    out_sat   <= sat_next;
                    acc       <= '0;
                    cnt       <= '0;
                    sat       <= 1'b0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    sat <= sat_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muladd2_dot_acc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_muladd2_dot_acc : scoreboard bench over three parameterisations
// Revision 1.0
// ============================================================================
module tb_muladd2_dot_acc;

    typedef struct {
        int acc;
        int beats;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: LANES=8 ACC_W=24, instance 1: LANES=8 ACC_W=8, instance 2: LANES=1 ACC_W=24
    logic        a_in_valid = 0, a_in_last = 0, a_out_ready = 1;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_sat;
    logic signed [23:0] a_out_acc;
    logic [15:0] a_out_beats;

    logic        b_in_valid = 0, b_in_last = 0, b_out_ready = 1;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_sat;
    logic signed [7:0] b_out_acc;
    logic [15:0] b_out_beats;

    logic        c_in_valid = 0, c_in_last = 0, c_out_ready = 1;
    logic [3:0]  c_in_data = '0;
    logic        c_in_ready, c_out_valid, c_out_sat;
    logic signed [23:0] c_out_acc;
    logic [15:0] c_out_beats;

    muladd2_dot_acc #(.LANES(8), .ACC_W(24), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_acc(a_out_acc), .out_beats(a_out_beats),
        .out_sat(a_out_sat));

    muladd2_dot_acc #(.LANES(8), .ACC_W(8), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_acc(b_out_acc), .out_beats(b_out_beats),
        .out_sat(b_out_sat));

    muladd2_dot_acc #(.LANES(1), .ACC_W(24), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_acc(c_out_acc), .out_beats(c_out_beats),
        .out_sat(c_out_sat));

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$], q1[$], q2[$];
    bit   use_model  = 0;
    bit   rand_ready = 0;
    int   a_irlow    = 0;

    longint m_acc[3];
    int     m_cnt[3];
    bit     m_sat[3];
    int     p_acc[3], p_beats[3];
    bit     p_sat[3], p_stall[3];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lanes_of(input int k);
        return (k == 2) ? 1 : 8;
    endfunction

    function automatic int accw_of(input int k);
        return (k == 1) ? 8 : 24;
    endfunction

    function automatic int code_val(input logic [1:0] c);
        int v[4] = '{-3, -1, 1, 3};
        return v[c];
    endfunction

    function automatic int beat_sum(input logic [31:0] d, input int lanes);
        int s = 0;
        for (int i = 0; i < lanes; i++)
            s += code_val(d[4*i +: 2]) * code_val(d[4*i+2 +: 2]);
        return s;
    endfunction

    task automatic push(input int k, input int acc, input int beats, input bit sat);
        exp_t e;
        e.acc = acc; e.beats = beats; e.sat = sat;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop(input int k, output exp_t e);
        case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        end
    endtask

    // Reference: exact integer sum, clamped to the accumulator range after every beat.
    task automatic model_accept(input int k, input logic [31:0] d, input bit l);
        longint mx = (longint'(1) << (accw_of(k) - 1)) - 1;
        longint mn = -mx - 1;
        longint t  = m_acc[k] + beat_sum(d, lanes_of(k));
        if (t > mx) begin t = mx; m_sat[k] = 1; end
        if (t < mn) begin t = mn; m_sat[k] = 1; end
        m_acc[k] = t;
        if (m_cnt[k] < 65535) m_cnt[k]++;
        if (l) begin
            if (use_model) push(k, int'(m_acc[k]), m_cnt[k], m_sat[k]);
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        end
    endtask

    task automatic drive(input int k, input bit v, input logic [31:0] d, input bit l);
        case (k)
            0: begin a_in_valid = v; a_in_data = d; a_in_last = l; end
            1: begin b_in_valid = v; b_in_data = d; b_in_last = l; end
            default: begin c_in_valid = v; c_in_data = d[3:0]; c_in_last = l; end
        endcase
    endtask

    function automatic bit rdy(input int k);
        case (k)
            0: return a_in_ready;
            1: return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    // Entered and left just after a rising edge.
    task automatic send(input int k, input logic [31:0] d, input bit l);
        int  n  = 0;
        bit  ok = 0;
        drive(k, 1'b1, d, l);
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rdy(k);
            n++;
            if (!ok) @(posedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        drive(k, 1'b0, $urandom, 1'b0);
        if (ok) model_accept(k, d, l);
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            drive(k, 1'b0, $urandom, 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) > 0 && n < 2000) begin
            @(posedge clk); n++;
        end
        #1;
        chk("drain_q0", qsize(0), 0);
        chk("drain_q1", qsize(1), 0);
        chk("drain_q2", qsize(2), 0);
    endtask

    task automatic mon(input int k, input bit v, input bit r, input bit ir,
                       input int acc, input int beats, input bit sat);
        exp_t e;
        if (rst) begin
            p_stall[k] = 0;
            return;
        end
        if (k == 0 && !ir) a_irlow++;
        if (p_stall[k]) begin
            chk("stall_acc_stable", acc, p_acc[k]);
            chk("stall_beats_stable", beats, p_beats[k]);
            chk("stall_sat_stable", sat, p_sat[k]);
        end
        if (v && !r) chk("in_ready_while_stalled", ir, 0);
        if (v && r) begin
            if (qsize(k) == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                pop(k, e);
                chk($sformatf("out_acc[%0d]", k), acc, e.acc);
                chk($sformatf("out_beats[%0d]", k), beats, e.beats);
                chk($sformatf("out_sat[%0d]", k), sat, e.sat);
            end
        end
        p_stall[k] = v && !r;
        p_acc[k] = acc; p_beats[k] = beats; p_sat[k] = sat;
    endtask

    always @(negedge clk) mon(0, a_out_valid, a_out_ready, a_in_ready, int'($signed(a_out_acc)), int'(a_out_beats), a_out_sat);
    always @(negedge clk) mon(1, b_out_valid, b_out_ready, b_in_ready, int'($signed(b_out_acc)), int'(b_out_beats), b_out_sat);
    always @(negedge clk) mon(2, c_out_valid, c_out_ready, c_in_ready, int'($signed(c_out_acc)), int'(c_out_beats), c_out_sat);

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            a_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int irlow_before;
        model_reset();

        // Reset state, sampled after a reset edge while rst is still high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_acc", a_out_acc, 0);
        chk("rst_out_beats", a_out_beats, 0);
        chk("rst_out_sat", a_out_sat, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", a_in_ready, 1);
        @(posedge clk); #1;

        // Three beats of all -3*-3, then latency check.
        use_model = 0;
        push(0, 216, 3, 0);
        send(0, 32'h0, 0);
        send(0, 32'h0, 0);
        send(0, 32'h0, 1);
        @(negedge clk);
        chk("latency_early_valid", a_out_valid, 0);
        @(negedge clk);
        chk("latency_due_valid", a_out_valid, 1);
        @(posedge clk); #1;

        push(0, -72, 1, 0);
        send(0, 32'hCCCC_CCCC, 1);

        // Saturation on the narrow accumulator, positive then flag cleared, then negative.
        push(1, 127, 4, 1);
        for (int i = 0; i < 4; i++) send(1, 32'h0, i == 3);
        push(1, -72, 1, 0);
        send(1, 32'hCCCC_CCCC, 1);
        push(1, -128, 3, 1);
        for (int i = 0; i < 3; i++) send(1, 32'hCCCC_CCCC, i == 2);

        // Every single-lane code combination.
        use_model = 1;
        for (int i = 0; i < 16; i++) send(2, 32'(i), 1);
        send(2, 32'h3, 0);
        send(2, 32'hF, 1);
        wait_drain();
        @(posedge clk); #1;

        // Back-to-back single-beat vectors with a 4-cycle output stall.
        irlow_before = a_irlow;
        fork
            begin
                for (int i = 0; i < 10; i++) send(0, $urandom, 1);
            end
            begin
                a_out_ready = 1;
                repeat (3) @(posedge clk);
                #1 a_out_ready = 0;
                repeat (4) @(posedge clk);
                #1 a_out_ready = 1;
            end
        join
        wait_drain();
        chk("in_ready_dropped", a_irlow > irlow_before, 1);
        @(posedge clk); #1;

        // Reset in the middle of a vector discards the partial sum.
        use_model = 0;
        send(0, 32'h0, 0);
        send(0, 32'h0, 0);
        rst = 1;
        @(negedge clk);
        chk("midrst_in_ready", a_in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_acc", a_out_acc, 0);
        chk("midrst_out_beats", a_out_beats, 0);
        chk("midrst_out_sat", a_out_sat, 0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        push(0, 144, 2, 0);
        send(0, 32'h0, 0);
        send(0, 32'h0, 1);
        wait_drain();
        @(posedge clk); #1;

        // Random traffic with random output backpressure and input bubbles.
        use_model  = 1;
        rand_ready = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) idle(0, $urandom_range(1, 3));
            send(0, $urandom, $urandom_range(0, 3) == 0);
        end
        send(0, $urandom, 1);
        rand_ready = 0;
        @(posedge clk); #2;
        a_out_ready = 1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
